scirc635c_tx: RTL and testbench
===============================

Name: scirc635c_tx

Overview:
- Parallel-to-serial transmitter: the sending end of the serial-load interface of the 4-bit left-shift register (serial data enters the receiver LSB, one bit per shift strobe).
- Accepts a W-bit word on a valid/ready handshake and emits it MSB-first on bstream_o, one shift_o strobe per bit.
- After W strobes the receiving register holds the word exactly; done_o then pulses once.

Parameters:
- W, 4, word width in bits; legal range W >= 2.
- DIV, 1, clocks per bit period; legal range DIV >= 1. Each bit is held for DIV clocks.

Ports:
- clk_i, input, 1, clock; all state updates on posedge.
- rst_i, input, 1, asynchronous active-low reset.
- I_i, input, W, parallel word to transmit.
- valid_i, input, 1, I_i is valid.
- ready_o, output, 1, transmitter can accept a word.
- abort_i, input, 1, synchronous abort of the word in flight.
- bstream_o, output, 1, serial data to the receiver's bstream input.
- shift_o, output, 1, one-clock strobe to the receiver's shift input.
- done_o, output, 1, one-clock pulse after the last bit completes.

Behaviour:
- Registers: state, W-bit shift register sreg, bit counter (clog2(W+1) bits), divider counter (clog2(DIV) bits, min 1).
- All outputs decode from registers only; no combinational path from any input to any output.
- Reset (rst_i=0, asynchronous): state=IDLE, sreg=0, both counters=0.
  - While rst_i=0: bstream_o=0, shift_o=0, done_o=0, ready_o=1.
  - Reset mid-word drops the word silently; no done_o.
- IDLE:
  - ready_o=1, bstream_o=0, shift_o=0.
  - On posedge with valid_i=1: sreg<=I_i, counters<=0, state<=SEND.
  - valid_i=0: stay in IDLE.
- SEND:
  - ready_o=0; bstream_o=sreg[W-1]; shift_o=1 only when divcnt==DIV-1.
  - Each posedge: divcnt increments, wrapping to 0 at DIV-1.
  - On the wrap posedge: sreg<=sreg<<1 (LSB filled 0) and bitcnt increments.
  - When the wrapping bit is bit W-1 (bitcnt==W-1): state<=DONE.
  - With DIV=1, shift_o is high on every SEND cycle.
- DONE:
  - Lasts exactly one cycle: done_o=1, ready_o=0, shift_o=0, bstream_o=0.
  - Then state<=IDLE.
- Latency (DIV=1, accept at edge k):
  - shift_o high during cycles k+1..k+W.
  - done_o high in cycle k+W+1.
  - ready_o high again from cycle k+W+2.
  - General case: W*DIV SEND cycles plus 1 DONE cycle.
- Handshake rules:
  - A word is accepted only on a posedge where ready_o=1 and valid_i=1.
  - valid_i and I_i are ignored while ready_o=0; I_i changes after acceptance have no effect.
  - Minimum inter-word spacing is W*DIV+2 clocks (one IDLE cycle between words).
- Abort:
  - abort_i=1 on a SEND posedge: state<=IDLE and counters<=0, with no done_o and no further shift_o.
  - abort_i is ignored in IDLE and DONE.
  - abort_i has priority over a simultaneous final-bit wrap: the word is not completed and done_o is not pulsed.
- Bit order: bit W-1 is emitted first, bit 0 last. A receiver shifting left with serial-in at the LSB therefore ends holding I_i.

Test Plan:
- W=4, DIV=1, send I_i=4'b1011: bstream_o=1,0,1,1 with shift_o high on 4 consecutive cycles; a connected behavioural 4-bit receiver (reset to 0) reads 4'b1011; done_o high exactly one cycle, in cycle 5 after accept; ready_o returns in cycle 6.
- W=4, DIV=3, send 4'b0110: each bit held 3 cycles, shift_o pulsed only in the 3rd cycle of each bit (4 pulses total); done_o 13 cycles after accept; receiver reads 4'b0110.
- valid_i held high with I_i=4'hA, then 4'h5 presented one cycle after accept and held: first word 1010 serialized unchanged; 4'h5 accepted only on the first ready_o=1 edge; receiver reads 4'hA, then 4'h5; no word lost or duplicated.
- Abort at the 2nd shift_o cycle of 4'b1111: no further shift_o, no done_o, ready_o=1 next cycle; a following 4'b0001 transmits cleanly.
- Abort coincident with the final-bit wrap: no done_o, state returns to IDLE; assert rst_i=0 mid-word of 4'hC: outputs go to reset values immediately (asynchronously), ready_o=1, and no stray shift_o or done_o after release.
- Random words, W=8, DIV in {1,2,5}: scoreboard checks receiver contents == I_i and the shift_o count == W per done_o; shift_o and done_o are never asserted together.

Source files
------------

// File: rtl/scirc635c_tx.sv
// Parallel-to-serial transmitter: sends a W-bit word MSB-first, one shift_o strobe per bit,
// holding each bit for DIV clocks, then pulses done_o for one cycle.
module scirc635c_tx #(
  parameter int W   = 4,
  parameter int DIV = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] I_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         abort_i,
  output logic         bstream_o,
  output logic         shift_o,
  output logic         done_o
);

  localparam int BCW = $clog2(W + 1);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(W - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sreg_q, sreg_d;
  logic [BCW-1:0] bitcnt_q, bitcnt_d;
  logic [DCW-1:0] divcnt_q, divcnt_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          sreg_d   = I_i;
          bitcnt_d = '0;
          divcnt_d = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        // Abort wins even over the final-bit wrap, so a cut word never reports done.
        if (abort_i) begin
          bitcnt_d = '0;
          divcnt_d = '0;
          state_d  = IDLE;
        end else if (divcnt_q == DIV_LAST) begin
          divcnt_d = '0;
          sreg_d   = {sreg_q[W-2:0], 1'b0};
          bitcnt_d = bitcnt_q + BCW'(1);
          if (bitcnt_q == BIT_LAST) state_d = DONE;
        end else begin
          divcnt_d = divcnt_q + DCW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registers only, so reset forces them asynchronously.
  assign ready_o   = (state_q == IDLE);
  assign bstream_o = (state_q == SEND) && sreg_q[W-1];
  assign shift_o   = (state_q == SEND) && (divcnt_q == DIV_LAST);
  assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_scirc635c_tx.sv
// Bench for scirc635c_tx: five instances (W/DIV variants) with behavioural receivers and a
// per-instance scoreboard of accepted words checked on every done_o.
module tb_scirc635c_tx;

  localparam int N = 5;
  localparam int WV[N] = '{4, 4, 8, 8, 8};
  localparam int DV[N] = '{1, 3, 1, 2, 5};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din  [N];
  logic       vld  [N];
  logic       abrt [N];
  logic       rdy  [N];
  logic       bs   [N];
  logic       sh   [N];
  logic       dn   [N];

  logic [7:0] exp_q [N][$];
  logic [7:0] rx    [N];
  int         shcnt [N];
  int         acc_cyc [N];
  int         n_done [N];
  logic       dn_prev [N];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  scirc635c_tx #(.W(4), .DIV(1)) u0 (.clk_i(clk), .rst_i(rst), .I_i(din[0][3:0]), .valid_i(vld[0]),
    .ready_o(rdy[0]), .abort_i(abrt[0]), .bstream_o(bs[0]), .shift_o(sh[0]), .done_o(dn[0]));
  scirc635c_tx #(.W(4), .DIV(3)) u1 (.clk_i(clk), .rst_i(rst), .I_i(din[1][3:0]), .valid_i(vld[1]),
    .ready_o(rdy[1]), .abort_i(abrt[1]), .bstream_o(bs[1]), .shift_o(sh[1]), .done_o(dn[1]));
  scirc635c_tx #(.W(8), .DIV(1)) u2 (.clk_i(clk), .rst_i(rst), .I_i(din[2]), .valid_i(vld[2]),
    .ready_o(rdy[2]), .abort_i(abrt[2]), .bstream_o(bs[2]), .shift_o(sh[2]), .done_o(dn[2]));
  scirc635c_tx #(.W(8), .DIV(2)) u3 (.clk_i(clk), .rst_i(rst), .I_i(din[3]), .valid_i(vld[3]),
    .ready_o(rdy[3]), .abort_i(abrt[3]), .bstream_o(bs[3]), .shift_o(sh[3]), .done_o(dn[3]));
  scirc635c_tx #(.W(8), .DIV(5)) u4 (.clk_i(clk), .rst_i(rst), .I_i(din[4]), .valid_i(vld[4]),
    .ready_o(rdy[4]), .abort_i(abrt[4]), .bstream_o(bs[4]), .shift_o(sh[4]), .done_o(dn[4]));

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: monitor all instances at the negedge (receiver shifts on the next posedge),
  // then return #1 after the posedge so stimulus changes away from the edge.
  task automatic tick();
    logic [7:0] e;
    int mask;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      mask = (1 << WV[i]) - 1;
      if (dn_prev[i]) chk("ready_after_done", int'(rdy[i]), 1);
      chk("shift_and_done", int'(sh[i] & dn[i]), 0);
      if (rst && rdy[i] && vld[i]) begin
        exp_q[i].push_back(din[i]);
        acc_cyc[i] = cyc;
      end
      if (sh[i]) begin
        rx[i] = {rx[i][6:0], bs[i]};
        shcnt[i]++;
        chk("shift_phase", (cyc - acc_cyc[i]) % DV[i], 0);
      end
      if (dn[i]) begin
        n_done[i]++;
        if (exp_q[i].size() == 0) chk("spurious_done", exp_q[i].size(), 1);
        else begin
          e = exp_q[i].pop_front();
          chk("rx_word", int'(rx[i]) & mask, int'(e) & mask);
          chk("shift_count", shcnt[i], WV[i]);
          chk("done_latency", cyc - acc_cyc[i], WV[i] * DV[i] + 1);
        end
        shcnt[i] = 0;
      end
      dn_prev[i] = dn[i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(int s);
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      if (exp_q[s].size() == 0 && rdy[s]) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk("wait_idle_timeout", exp_q[s].size(), 0);
  endtask

  task automatic send(int s, logic [7:0] w);
    din[s] = w;
    vld[s] = 1'b1;
    tick();
    vld[s] = 1'b0;
    din[s] = 8'($urandom);
  endtask

  task automatic drop_all();
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      shcnt[i] = 0;
    end
  endtask

  initial begin
    int nd;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      din[i] = '0; vld[i] = 1'b0; abrt[i] = 1'b0; rx[i] = '0;
      shcnt[i] = 0; acc_cyc[i] = 0; n_done[i] = 0; dn_prev[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < N; i++) begin
      chk("rst_ready", int'(rdy[i]), 1);
      chk("rst_shift", int'(sh[i]), 0);
      chk("rst_done", int'(dn[i]), 0);
      chk("rst_bstream", int'(bs[i]), 0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // basic word, DIV=1 and DIV=3
    send(0, 8'b1011);
    wait_idle(0);
    send(1, 8'b0110);
    wait_idle(1);
    chk("done_count_basic", n_done[0] + n_done[1], 2);

    // valid held across a word: second word taken only once ready returns
    nd = n_done[0];
    din[0] = 8'hA; vld[0] = 1'b1;
    tick();
    din[0] = 8'h5;
    repeat (6) tick();
    vld[0] = 1'b0;
    wait_idle(0);
    chk("b2b_done_count", n_done[0] - nd, 2);

    // abort on the 2nd shift cycle
    nd = n_done[0];
    send(0, 8'b1111);
    tick();
    abrt[0] = 1'b1;
    tick();
    abrt[0] = 1'b0;
    drop_all();
    chk("abort_ready", int'(rdy[0]), 1);
    chk("abort_shift", int'(sh[0]), 0);
    repeat (4) tick();
    chk("abort_no_shift", shcnt[0], 0);
    chk("abort_no_done", n_done[0] - nd, 0);
    send(0, 8'b0001);
    wait_idle(0);

    // abort coincident with the final-bit wrap
    nd = n_done[0];
    send(0, 8'b1001);
    repeat (3) tick();
    abrt[0] = 1'b1;
    tick();
    abrt[0] = 1'b0;
    drop_all();
    chk("final_abort_ready", int'(rdy[0]), 1);
    repeat (4) tick();
    chk("final_abort_no_done", n_done[0] - nd, 0);
    chk("final_abort_no_shift", shcnt[0], 0);

    // asynchronous reset mid-word
    nd = n_done[0];
    send(0, 8'hC);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", int'(rdy[0]), 1);
    chk("arst_shift", int'(sh[0]), 0);
    chk("arst_done", int'(dn[0]), 0);
    chk("arst_bstream", int'(bs[0]), 0);
    drop_all();
    repeat (2) tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("arst_no_shift", shcnt[0], 0);
    chk("arst_no_done", n_done[0] - nd, 0);

    // random words on the W=8 instances
    for (int s = 2; s < N; s++) begin
      nd = n_done[s];
      for (int k = 0; k < 8; k++) begin
        wait_idle(s);
        repeat ($urandom_range(0, 2)) tick();
        send(s, 8'($urandom));
      end
      wait_idle(s);
      chk("rand_done_count", n_done[s] - nd, 8);
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
